pwm_generator: RTL and testbench
================================

# pwm_generator

Tick-driven pulse-width modulator that sits directly downstream of the clock-divider downcounter. Its `enable` input takes the downcounter's one-cycle `zero` pulse, so each PWM step lasts one divider period. The block produces a glitch-free PWM waveform whose duty cycle is sampled only at period boundaries, plus a one-cycle end-of-period pulse. Consumers are LED/backlight dimming and display-brightness logic.

## Interface
Parameters:
- `WIDTH`, default 8: counter and duty width; the PWM period is 2^WIDTH steps.
- `DEAD`, default 2: dead-time in steps; used only when the Configuration macro is defined; legal range 0 to 2^(WIDTH-1)-1.

Ports:
- `clk`  input  1  system clock; the only clock.
- `reset`  input  1  synchronous, active-high reset.
- `enable`  input  1  step strobe, normally the downcounter `zero` pulse; may also be held high continuously.
- `duty`  input  WIDTH  requested high-time in steps; sampled only at period wrap.
- `pwm_out`  output  1  registered PWM output.
- `pwm_n`  output  1  registered complementary output with dead-time. Constant 0 when the feature is compiled out.
- `period_done`  output  1  one-cycle pulse when the step counter wraps.

## Operation
Internal state:
- `cnt`: WIDTH bits, counts up.
- `duty_s`: WIDTH-bit shadow of `duty`.

On a cycle with `enable`=1:
- `cnt` advances to `cnt_next` = `cnt`+1, wrapping from 2^WIDTH-1 to 0.
- If `cnt` = 2^WIDTH-1 at that edge:
  - `duty_s` <= `duty`.
  - `period_done` <= 1.
  - The new period uses the newly loaded `duty_s` starting at step 0.
- `pwm_out` <= (`cnt_next` < effective duty).
  - Effective duty is the newly loaded value at a wrap, otherwise the held `duty_s`.

On a cycle with `enable`=0:
- `cnt`, `duty_s` and `pwm_out` hold.
- `period_done` <= 0.

Duty boundaries:
- `duty`=0: `pwm_out` stays low for the whole period.
- `duty`=2^WIDTH-1: `pwm_out` is high for all steps except the last one.
- 100% duty is not representable by design.

Duty-change rule:
- Changing `duty` mid-period has no effect until the next wrap.
- `duty` needs to be stable only in the cycle in which the wrap occurs.

Reset (applies at any time, including mid-period): `cnt`=0, `duty_s`=0, `pwm_out`=0, `pwm_n`=0, `period_done`=0. The first period after reset therefore outputs low. The first `duty` value is sampled at the first wrap, 2^WIDTH enables after reset.

`reset` and `enable` in the same cycle: reset wins.

## Timing
- All outputs are registered; no combinational path from input to output.
- Latency: `pwm_out` and `pwm_n` reflect the new step in the clock cycle immediately after the enabling edge.
- `period_done` is high for exactly one clk cycle, in the cycle after the wrapping enable.
  - It repeats every 2^WIDTH enables.
  - With `enable` held high, that is every 2^WIDTH clocks.
- No minimum spacing between enables; back-to-back enables are legal.

## Configuration
- `PWM_DEADTIME_EN` defined:
  - `pwm_n` <= 1 when `cnt_next` is in the range [`duty_s`+DEAD, 2^WIDTH-DEAD).
  - The comparison uses WIDTH+1-bit arithmetic, so there is no wrap in the sum.
  - If the range is empty, `pwm_n` stays 0.
  - Consequently `pwm_out` and `pwm_n` are never high together, and at least DEAD steps separate each edge of one from the opposite edge of the other, including across the period wrap.
- `PWM_DEADTIME_EN` undefined:
  - `pwm_n` is tied to 0.
  - DEAD is ignored.
  - No dead-time logic is synthesised.

## Test plan
All scenarios use WIDTH=4.
- Reset, then `duty`=5 with `enable` held high:
  - First 16 clocks: `pwm_out`=0.
  - `period_done` pulses on the 16th cycle after the first enable.
  - Next period: `pwm_out` high for steps 0–4 (5 clocks) and low for 11 clocks.
- `enable` as a 1-in-4 strobe with `duty`=8:
  - Each step lasts 4 clocks.
  - `pwm_out` high for 32 clocks, low for 32 clocks.
  - `period_done` is exactly 1 clock wide.
- Change `duty` from 3 to 12 at step 6:
  - The current period stays at 3 high steps.
  - The next period has 12 high steps.
- Boundary values:
  - `duty`=0: `pwm_out` is never high.
  - `duty`=15: `pwm_out` is low only at step 15.
- Assert `reset` at step 9 with `duty_s`=10, with `enable`=1 in the same cycle:
  - The next cycle shows all outputs 0 and `cnt`=0.
  - The next `period_done` comes 16 enables later.
- With `PWM_DEADTIME_EN` defined, DEAD=2, `duty`=6:
  - `pwm_n` high for steps 8–13.
  - `pwm_out` & `pwm_n` is never 1.
  - Without the macro, `pwm_n`=0 throughout.

Source files
------------

// File: rtl/pwm_generator.sv
// pwm_generator: tick-driven PWM with period-boundary duty sampling; optional dead-time complementary output (PWM_DEADTIME_EN).
module pwm_generator #(
  parameter int WIDTH = 8,
  parameter int DEAD = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm_out,
  output logic             pwm_n,
  output logic             period_done
);
  logic [WIDTH-1:0] cnt, duty_s, cnt_next, duty_eff;
  logic wrap;
  assign cnt_next = cnt + 1'b1;
  assign wrap = &cnt;
  assign duty_eff = wrap ? duty : duty_s;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      duty_s <= '0;
      pwm_out <= 1'b0;
      period_done <= 1'b0;
    end else begin
      period_done <= enable & wrap;
      if (enable) begin
        cnt <= cnt_next;
        pwm_out <= cnt_next < duty_eff;
        if (wrap) duty_s <= duty;
      end
    end
  end
`ifdef PWM_DEADTIME_EN
  // widened by one bit so duty+DEAD cannot wrap
  localparam logic [WIDTH:0] DW = (WIDTH+1)'(DEAD);
  localparam logic [WIDTH:0] TOP = (WIDTH+1)'((1 << WIDTH) - DEAD);
  logic [WIDTH:0] nx, lo;
  assign nx = {1'b0, cnt_next};
  assign lo = {1'b0, duty_eff} + DW;
  always_ff @(posedge clk) begin
    if (reset) pwm_n <= 1'b0;
    else if (enable) pwm_n <= (nx >= lo) && (nx < TOP);
  end
`else
  assign pwm_n = 1'b0;
`endif
endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: directed checks of pwm_generator at WIDTH=4.
module tb_pwm_generator;
  logic clk = 0, reset = 1, enable = 0;
  logic [3:0] duty = 0;
  logic pwm_out, pwm_n, period_done;
  int checks = 0, errors = 0;

  pwm_generator #(.WIDTH(4), .DEAD(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .duty(duty),
    .pwm_out(pwm_out), .pwm_n(pwm_n), .period_done(period_done)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic e, input logic r);
    enable = e;
    reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic pn(input int s, input int d);
`ifdef PWM_DEADTIME_EN
    return (s >= d + 2) && (s < 14);
`else
    return 1'b0;
`endif
  endfunction

  task automatic stp(input string tag, input int s, input int d, input logic pd);
    chk({tag, "_pwm"}, {7'd0, pwm_out}, {7'd0, s < d});
    chk({tag, "_pd"}, {7'd0, period_done}, {7'd0, pd});
    chk({tag, "_pwmn"}, {7'd0, pwm_n}, {7'd0, pn(s, d)});
    chk({tag, "_ovl"}, {7'd0, pwm_out & pwm_n}, 8'd0);
  endtask

  initial begin
    duty = 5;
    tick(0, 1);
    tick(0, 1);
    chk("rst_pwm", {7'd0, pwm_out}, 8'd0);
    chk("rst_pwmn", {7'd0, pwm_n}, 8'd0);
    chk("rst_pd", {7'd0, period_done}, 8'd0);
    // first period after reset runs with duty_s=0
    for (int i = 0; i < 15; i++) begin
      tick(1, 0);
      stp("A1", i + 1, 0, 0);
    end
    tick(1, 0);
    stp("A1wrap", 0, 5, 1);
    for (int s = 1; s < 16; s++) begin
      tick(1, 0);
      stp("A2", s, 5, 0);
    end
    duty = 8;
    for (int s = 0; s < 16; s++) begin
      tick(1, 0);
      stp("B", s, 8, s == 0);
      for (int k = 0; k < 3; k++) begin
        tick(0, 0);
        stp("Bhold", s, 8, 0);
      end
    end
    duty = 3;
    for (int s = 0; s < 16; s++) begin
      if (s == 6) duty = 12;
      tick(1, 0);
      stp("C3", s, 3, s == 0);
    end
    for (int s = 0; s < 16; s++) begin
      if (s == 8) duty = 0;
      tick(1, 0);
      stp("C12", s, 12, s == 0);
    end
    for (int s = 0; s < 16; s++) begin
      if (s == 5) duty = 15;
      tick(1, 0);
      stp("D0", s, 0, s == 0);
    end
    for (int s = 0; s < 16; s++) begin
      if (s == 3) duty = 6;
      tick(1, 0);
      stp("D15", s, 15, s == 0);
    end
    for (int s = 0; s < 16; s++) begin
      if (s == 1) duty = 10;
      tick(1, 0);
      stp("E6", s, 6, s == 0);
    end
    for (int s = 0; s < 9; s++) begin
      tick(1, 0);
      stp("R10", s, 10, s == 0);
    end
    // reset and enable together at step 9: reset wins
    tick(1, 1);
    chk("rr_pwm", {7'd0, pwm_out}, 8'd0);
    chk("rr_pwmn", {7'd0, pwm_n}, 8'd0);
    chk("rr_pd", {7'd0, period_done}, 8'd0);
    chk("rr_cnt", {4'd0, dut.cnt}, 8'd0);
    for (int i = 0; i < 15; i++) begin
      tick(1, 0);
      stp("R2", i + 1, 0, 0);
    end
    tick(1, 0);
    stp("R2wrap", 0, 10, 1);
    tick(0, 0);
    stp("R2idle", 0, 10, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
